// File: rtl/pwm_gen.sv
// PWM generator driven by an external free-running 8-bit counter, with a
// double-buffered duty register. Optional dead time is compiled in with PWM_DEADTIME_EN.
module pwm_gen #(
    parameter logic [7:0]  INIT_DUTY = 8'h80,
    parameter int unsigned DEAD      = 4
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] cnt,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic       period_start
);

    // DEAD is range-checked in every build so toggling the macro never breaks elaboration
    if (DEAD == 0 || DEAD > 15) begin : g_dead_range
        $error("pwm_gen: DEAD must be in 1..15");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mode_t;

    mode_t      mode;
    logic       armed;
    logic       armed_next;
    logic       st;
    logic       hs;
    logic [7:0] cnt_q;
    logic       pend_full;
    logic [7:0] pend_duty;
    logic [7:0] act_duty;
    logic [7:0] eff;
    logic       pwm_next;
    logic       pwm_q;

    function automatic logic pwm_cmp(input logic en, input logic [7:0] c, input logic [7:0] d);
        return en && (c < d);
    endfunction

    assign armed      = (mode == RUN);
    assign duty_ready = !pend_full;

    always_comb begin
        st         = (cnt == 8'h00) && ((cnt_q == 8'hFF) || !armed);
        armed_next = armed || st;
        hs         = duty_valid && !pend_full;
        eff        = (st && pend_full) ? pend_duty : act_duty;
        pwm_next   = pwm_cmp(armed_next, cnt, eff);
    end

    // p0 -> p1: mode, duty buffering and registered compare
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mode         <= IDLE;
            cnt_q        <= 8'h00;
            pend_full    <= 1'b0;
            act_duty     <= INIT_DUTY;
            pwm_q        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt_q        <= cnt;
            pwm_q        <= pwm_next;
            period_start <= st;
            case (mode)
                IDLE:    if (st) mode <= RUN;
                RUN:     mode <= RUN;
                default: mode <= IDLE;
            endcase
            if (st && pend_full) begin
                act_duty  <= pend_duty;
                pend_full <= 1'b0;
            end
            // a handshake can only occur with the slot empty, so it never races the consume above
            if (hs) begin
                pend_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            pend_duty <= duty_in;
        end
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [3:0] DEAD_LD = 4'(DEAD);

    logic [3:0] dc;

    // p1: dead-time counter restarts on every compare change, including one mid dead time
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dc <= 4'd0;
        end else if (pwm_next != pwm_q) begin
            dc <= DEAD_LD;
        end else if (dc != 4'd0) begin
            dc <= dc - 4'd1;
        end
    end

    assign pwm_h = pwm_q && (dc == 4'd0);
    assign pwm_l = !pwm_q && armed && (dc == 4'd0);
`else
    assign pwm_h = pwm_q;
    assign pwm_l = !pwm_q && armed;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Randomised and directed bench for pwm_gen against a period-level reference model.
module tb_pwm_gen;

    localparam int TB_DEAD = 4;
`ifdef PWM_DEADTIME_EN
    localparam int DT = TB_DEAD;
`else
    localparam int DT = 0;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [7:0] cnt = 8'h00;
    logic [7:0] duty_in = 8'h00;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_start;

    pwm_gen #(
        .INIT_DUTY (8'h80),
        .DEAD      (TB_DEAD)
    ) dut (
        .clk          (clk),
        .res          (res),
        .cnt          (cnt),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int next_cnt = 0;

    // reference model: period bookkeeping plus a one-entry pending queue
    bit m_run;
    int m_prev;
    int m_act;
    int pend_q[$];
    bit m_raw;
    int since;
    bit e_h, e_l, e_ps, e_rdy;

    task automatic model_reset();
        m_run = 0; m_prev = 0; m_act = 8'h80; pend_q.delete();
        m_raw = 0; since = TB_DEAD;
        e_h = 0; e_l = 0; e_ps = 0; e_rdy = 1;
    endtask

    task automatic model_edge(input int c, input bit v, input int d);
        bit start, accept, dead_ok;
        start  = (c == 0) && (!m_run || m_prev == 255);
        accept = v && (pend_q.size() == 0);
        if (start && pend_q.size() > 0) m_act = pend_q.pop_front();
        if (accept) pend_q.push_back(d);
        if (start) m_run = 1;
        if ((m_run && c < m_act) != m_raw) since = 0;
        else if (since < TB_DEAD) since++;
        m_raw   = m_run && (c < m_act);
        m_prev  = c;
        dead_ok = (DT == 0) || (since >= TB_DEAD);
        e_ps  = start;
        e_h   = m_raw && dead_ok;
        e_l   = !m_raw && m_run && dead_ok;
        e_rdy = (pend_q.size() == 0);
    endtask

    task automatic tick(input bit v, input logic [7:0] d);
        @(negedge clk);
        cnt = next_cnt[7:0];
        duty_valid = v;
        duty_in = d;
        @(posedge clk);
        if (res) model_edge(next_cnt, v, int'(d));
        else model_reset();
        next_cnt = (next_cnt + 1) % 256;
        #1;
    endtask

    // one full period starting at cnt=0; optional single-cycle write at index hs_at
    task automatic run_period(input int hs_at, input logic [7:0] hs_val,
                              output int nh, output int nl, output int nps, output int bad);
        nh = 0; nl = 0; nps = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick(i == hs_at, hs_val);
            nh += int'(pwm_h);
            nl += int'(pwm_l);
            nps += int'(period_start);
            if ({pwm_h, pwm_l, period_start, duty_ready} !== {e_h, e_l, e_ps, e_rdy}) bad++;
        end
    endtask

    task automatic test_reset();
        res = 1'b0;
        model_reset();
        next_cnt = 8'hFB;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h22);
            vectors++;
            if ({pwm_h, pwm_l, period_start, duty_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL reset_state got h/l/ps/rdy=%b required 0001", {pwm_h, pwm_l, period_start, duty_ready});
            end
        end
        res = 1'b1;
    endtask

    task automatic test_default();
        int nh, nl, nps, bad;
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (bad !== 0 || nps !== 1) begin
            miscompares++;
            $display("FAIL default_first got bad=%0d starts=%0d required 0 and 1", bad, nps);
        end
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 128 - DT || nl !== 128 - DT || bad !== 0) begin
            miscompares++;
            $display("FAIL default_duty got h=%0d l=%0d bad=%0d required h=%0d l=%0d bad=0", nh, nl, bad, 128 - DT, 128 - DT);
        end
    endtask

    task automatic test_duty_mid();
        int nh, nl, nps, bad;
        run_period(8'h30, 8'h40, nh, nl, nps, bad);
        vectors++;
        if (nh !== 128 - DT || bad !== 0) begin
            miscompares++;
            $display("FAIL mid_write_current got h=%0d bad=%0d required %0d and 0", nh, bad, 128 - DT);
        end
        vectors++;
        if (duty_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_write_ready got %b required 0", duty_ready);
        end
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 64 - DT || bad !== 0) begin
            miscompares++;
            $display("FAIL mid_write_next got h=%0d bad=%0d required %0d and 0", nh, bad, 64 - DT);
        end
    endtask

    task automatic test_extremes();
        int nh, nl, nps, bad;
        run_period(10, 8'h00, nh, nl, nps, bad);
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 0 || nl !== 256 || bad !== 0) begin
            miscompares++;
            $display("FAIL duty_00 got h=%0d l=%0d bad=%0d required h=0 l=256 bad=0", nh, nl, bad);
        end
        run_period(5, 8'hFF, nh, nl, nps, bad);
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 255 - DT || nl !== ((DT > 0) ? 0 : 1) || bad !== 0) begin
            miscompares++;
            $display("FAIL duty_ff got h=%0d l=%0d bad=%0d required h=%0d l=%0d bad=0", nh, nl, bad, 255 - DT, (DT > 0) ? 0 : 1);
        end
    endtask

    task automatic test_st_handshake();
        int nh, nl, nps, bad;
        run_period(0, 8'h10, nh, nl, nps, bad);
        vectors++;
        if (nh !== 255 - DT || bad !== 0) begin
            miscompares++;
            $display("FAIL st_write_current got h=%0d bad=%0d required %0d and 0", nh, bad, 255 - DT);
        end
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 16 - DT || bad !== 0) begin
            miscompares++;
            $display("FAIL st_write_next got h=%0d bad=%0d required %0d and 0", nh, bad, 16 - DT);
        end
    endtask

    task automatic test_reset_mid();
        int nh, nl, nps, bad;
        for (int i = 0; i < 8'h50; i++) tick(1'b0, 8'h00);
        res = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({pwm_h, pwm_l, period_start, duty_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_async got h/l/ps/rdy=%b required 0001", {pwm_h, pwm_l, period_start, duty_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h33);
            vectors++;
            if ({pwm_h, pwm_l, period_start, duty_ready} !== 4'b0001) begin
                miscompares++;
                $display("FAIL reset_hold got h/l/ps/rdy=%b required 0001", {pwm_h, pwm_l, period_start, duty_ready});
            end
        end
        res = 1'b1;
        while (next_cnt != 0) begin
            tick(1'b0, 8'h00);
            vectors++;
            if ({pwm_h, pwm_l, period_start, duty_ready} !== {e_h, e_l, e_ps, e_rdy}) begin
                miscompares++;
                $display("FAIL reset_idle got h/l/ps/rdy=%b required %b", {pwm_h, pwm_l, period_start, duty_ready}, {e_h, e_l, e_ps, e_rdy});
            end
        end
        run_period(-1, 8'h00, nh, nl, nps, bad);
        vectors++;
        if (nh !== 128 - DT || nps !== 1 || bad !== 0) begin
            miscompares++;
            $display("FAIL reset_resume got h=%0d starts=%0d bad=%0d required %0d 1 0", nh, nps, bad, 128 - DT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) next_cnt = $urandom_range(0, 255);
            tick($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)));
            vectors++;
            if ({pwm_h, pwm_l, period_start, duty_ready} !== {e_h, e_l, e_ps, e_rdy}) begin
                miscompares++;
                $display("FAIL random cnt=%0d got h/l/ps/rdy=%b required %b", cnt, {pwm_h, pwm_l, period_start, duty_ready}, {e_h, e_l, e_ps, e_rdy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_duty_mid();
        test_extremes();
        test_st_handshake();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
